// File: rtl/sha_out_pkg.sv
// sha_out_pkg: shared widths, clog2 helper and beat/tag types for the SHA output serializer
package sha_out_pkg;
  localparam int SHA_STATE_W = 1600;
  localparam int SHA_BEAT_W = 200;
  localparam int SHA_TAG_W = 8;
  typedef logic [SHA_BEAT_W-1:0] beat_t;
  typedef logic [SHA_TAG_W-1:0] tag_t;
  function automatic int clog2(int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/sha_out_wordbuf.sv
// sha_out_wordbuf: N-entry word+tag FIFO exposing head, count, push and pop
module sha_out_wordbuf import sha_out_pkg::*; #(
  parameter int W = SHA_STATE_W,
  parameter int TW = SHA_TAG_W,
  parameter int N = 2,
  parameter int CW = clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  input  logic [TW-1:0] tagin,
  output logic [W-1:0]  head,
  output logic [TW-1:0] headtag,
  output logic [CW-1:0] count
);
  localparam int PW = N > 1 ? clog2(N) : 1;
  logic [W-1:0] mem [N];
  logic [TW-1:0] tags [N];
  logic [PW-1:0] rp, wp;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(N - 1) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk)
    if (reset) begin
      mem <= '{default: '0};
      tags <= '{default: '0};
      rp <= '0;
      wp <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        tags[wp] <= tagin;
        wp <= inc(wp);
      end
      if (pop) rp <= inc(rp);
      count <= count + CW'(push) - CW'(pop);
    end
  assign head = mem[rp];
  assign headtag = tags[rp];
endmodule

// File: rtl/sha_out_serializer.sv
// sha_out_serializer: buffers tagged words and emits them as DOUT_W beats, lowest slice first
// Optional byte parity output parout when SHA_OUT_PARITY_EN is defined.
module sha_out_serializer import sha_out_pkg::*; #(
  parameter int DIN_W = SHA_STATE_W,
  parameter int DOUT_W = SHA_BEAT_W,
  parameter int TAG_W = SHA_TAG_W,
  parameter int NBUF = 2,
  localparam int NBEATS = DIN_W / DOUT_W,
  localparam int IX_W = clog2(NBEATS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pushin,
  input  logic [DIN_W-1:0]  din,
  input  logic [TAG_W-1:0]  tagin,
  output logic              rdyout,
  output logic              pushout,
  output logic [DOUT_W-1:0] dout,
  output logic [IX_W-1:0]   doutix,
  output logic [TAG_W-1:0]  tagout,
  output logic              lastout,
  input  logic              stopin
`ifdef SHA_OUT_PARITY_EN
  ,
  output logic [DOUT_W/8-1:0] parout
`endif
);
  localparam int CW = clog2(NBUF + 1);
  logic [DIN_W-1:0] head;
  logic [CW-1:0] count;
  logic adv;
  sha_out_wordbuf #(.W(DIN_W), .TW(TAG_W), .N(NBUF), .CW(CW)) u_buf (
    .clk(clk), .reset(reset), .push(pushin && rdyout), .pop(adv && lastout),
    .din(din), .tagin(tagin), .head(head), .headtag(tagout), .count(count)
  );
  always_comb begin
    rdyout = count < CW'(NBUF);
    pushout = count != '0;
    adv = pushout && !stopin;
    lastout = doutix == IX_W'(NBEATS - 1);
    dout = head[doutix*DOUT_W +: DOUT_W];
  end
  always_ff @(posedge clk)
    if (reset) doutix <= '0;
    else if (adv) doutix <= lastout ? '0 : doutix + 1'b1;
`ifdef SHA_OUT_PARITY_EN
  for (genvar i = 0; i < DOUT_W / 8; i++) begin : g_par
    assign parout[i] = ^dout[8*i +: 8];
  end
`endif
endmodule

// File: tb/tb_sha_out_serializer.sv
// tb_sha_out_serializer: directed tests for sha_out_serializer (default and 64/16 instances)
module tb_sha_out_serializer;
  logic clk = 0, reset = 1;
  logic pushin = 0, stopin = 0;
  logic [1599:0] din = '0;
  logic [7:0] tagin = '0;
  logic rdyout, pushout, lastout;
  logic [199:0] dout;
  logic [2:0] doutix;
  logic [7:0] tagout;
  logic s_pushin = 0, s_stopin = 0;
  logic [63:0] s_din = '0;
  logic [7:0] s_tagin = '0;
  logic s_rdyout, s_pushout, s_lastout;
  logic [15:0] s_dout;
  logic [1:0] s_doutix;
  logic [7:0] s_tagout;
`ifdef SHA_OUT_PARITY_EN
  logic [1:0] s_parout;
  logic [24:0] parout;
`endif
  int errors = 0, checks = 0;

  sha_out_serializer dut (
    .clk(clk), .reset(reset), .pushin(pushin), .din(din), .tagin(tagin), .rdyout(rdyout),
    .pushout(pushout), .dout(dout), .doutix(doutix), .tagout(tagout), .lastout(lastout),
    .stopin(stopin)
`ifdef SHA_OUT_PARITY_EN
    , .parout(parout)
`endif
  );
  sha_out_serializer #(.DIN_W(64), .DOUT_W(16), .TAG_W(8), .NBUF(2)) sdut (
    .clk(clk), .reset(reset), .pushin(s_pushin), .din(s_din), .tagin(s_tagin), .rdyout(s_rdyout),
    .pushout(s_pushout), .dout(s_dout), .doutix(s_doutix), .tagout(s_tagout), .lastout(s_lastout),
    .stopin(s_stopin)
`ifdef SHA_OUT_PARITY_EN
    , .parout(s_parout)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [1599:0] word(input int w);
    logic [1599:0] r;
    for (int k = 0; k < 8; k++) r[k*200 +: 200] = {50{4'((k + w) % 16)}};
    return r;
  endfunction
  function automatic logic [199:0] slice(input int w, input int k);
    return {50{4'((k + w) % 16)}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    step();
    step();
    checks++; if (pushout !== 1'b0) begin errors++; $display("FAIL reset_pushout got %b want 0", pushout); end
    checks++; if (rdyout !== 1'b1) begin errors++; $display("FAIL reset_rdyout got %b want 1", rdyout); end
    checks++; if (doutix !== 3'd0) begin errors++; $display("FAIL reset_doutix got %0d want 0", doutix); end
    checks++; if (dout !== '0 || tagout !== 8'h00 || lastout !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got dout_nonzero=%b tag=%h last=%b want 0", dout != '0, tagout, lastout); end
`ifdef SHA_OUT_PARITY_EN
    checks++; if (parout !== '0 || s_parout !== 2'b00) begin errors++; $display("FAIL reset_parout got %h/%b want 0", parout, s_parout); end
`endif
    reset = 0;
  endtask

  task automatic test_single_word();
    pushin = 1; din = word(0); tagin = 8'hA5;
    step();
    pushin = 0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (pushout !== 1'b1 || doutix !== 3'(k) || dout !== slice(0, k) || tagout !== 8'hA5 ||
          lastout !== (k == 7) || rdyout !== 1'b1) begin
        errors++; $display("FAIL single_beat%0d got push=%b ix=%0d tag=%h last=%b rdy=%b dout_ok=%b want 1 %0d a5 %b 1 1",
                           k, pushout, doutix, tagout, lastout, rdyout, dout === slice(0, k), k, k == 7);
      end
      step();
    end
    checks++; if (pushout !== 1'b0) begin errors++; $display("FAIL single_idle got %b want 0", pushout); end
  endtask

  task automatic test_back_to_back();
    int beat = 0, first = -1, lastc = -1;
    for (int c = 0; c < 22; c++) begin
      pushin = c < 3; din = word(c + 1); tagin = 8'h11 * 8'(c + 1);
      if (c < 3) begin
        checks++;
        if (rdyout !== (c < 2)) begin errors++; $display("FAIL b2b_rdy%0d got %b want %b", c, rdyout, c < 2); end
      end
      if (pushout) begin
        checks++;
        if (doutix !== 3'(beat % 8) || tagout !== (beat < 8 ? 8'h11 : 8'h22) ||
            dout !== slice(beat / 8 + 1, beat % 8)) begin
          errors++; $display("FAIL b2b_beat%0d got ix=%0d tag=%h want ix=%0d tag=%h", beat, doutix, tagout,
                             beat % 8, beat < 8 ? 8'h11 : 8'h22);
        end
        if (first < 0) first = c;
        lastc = c;
        beat++;
      end
      step();
    end
    pushin = 0;
    checks++; if (beat !== 16) begin errors++; $display("FAIL b2b_count got %0d want 16", beat); end
    checks++; if (lastc - first !== 15) begin errors++; $display("FAIL b2b_gapfree got span %0d want 15", lastc - first); end
  endtask

  task automatic test_stall();
    pushin = 1; din = word(3); tagin = 8'h05;
    step();
    pushin = 0;
    for (int k = 0; k < 4; k++) step();
    checks++; if (doutix !== 3'd4) begin errors++; $display("FAIL stall_pre got %0d want 4", doutix); end
    stopin = 1;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (pushout !== 1'b1 || doutix !== 3'd4 || dout !== slice(3, 4) || tagout !== 8'h05 || lastout !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d got push=%b ix=%0d tag=%h want 1 4 05", s, pushout, doutix, tagout);
      end
      step();
    end
    stopin = 0;
    for (int k = 4; k < 8; k++) begin
      checks++;
      if (pushout !== 1'b1 || doutix !== 3'(k) || dout !== slice(3, k)) begin
        errors++; $display("FAIL stall_resume%0d got push=%b ix=%0d want 1 %0d", k, pushout, doutix, k);
      end
      step();
    end
    checks++; if (pushout !== 1'b0) begin errors++; $display("FAIL stall_end got %b want 0", pushout); end
  endtask

  task automatic test_full_pop_push();
    int n = 0;
    pushin = 1; din = word(4); tagin = 8'h01;
    step();
    din = word(5); tagin = 8'h02;
    step();
    pushin = 0;
    while (!lastout && n < 20) begin step(); n++; end
    checks++; if (doutix !== 3'd7 || tagout !== 8'h01) begin errors++; $display("FAIL full_last got ix=%0d tag=%h want 7 01", doutix, tagout); end
    pushin = 1; din = word(6); tagin = 8'h03;
    checks++; if (rdyout !== 1'b0) begin errors++; $display("FAIL full_rdy_pop got %b want 0", rdyout); end
    step();
    checks++; if (rdyout !== 1'b1 || tagout !== 8'h02 || doutix !== 3'd0) begin
      errors++; $display("FAIL full_rdy_next got rdy=%b tag=%h ix=%0d want 1 02 0", rdyout, tagout, doutix); end
    step();
    pushin = 0;
    for (int i = 1; i < 16; i++) begin
      checks++;
      if (pushout !== 1'b1 || doutix !== 3'(i % 8) || tagout !== (i < 8 ? 8'h02 : 8'h03)) begin
        errors++; $display("FAIL full_beat%0d got push=%b ix=%0d tag=%h want 1 %0d %h", i, pushout, doutix, tagout,
                           i % 8, i < 8 ? 8'h02 : 8'h03);
      end
      step();
    end
    checks++; if (pushout !== 1'b0) begin errors++; $display("FAIL full_end got %b want 0", pushout); end
  endtask

  task automatic test_reset_mid();
    pushin = 1; din = word(7); tagin = 8'h09;
    step();
    din = word(8); tagin = 8'h0A;
    step();
    pushin = 0;
    step();
    step();
    checks++; if (doutix !== 3'd3) begin errors++; $display("FAIL midrst_pre got %0d want 3", doutix); end
    reset = 1;
    step();
    checks++; if (pushout !== 1'b0 || doutix !== 3'd0 || rdyout !== 1'b1) begin
      errors++; $display("FAIL midrst_state got push=%b ix=%0d rdy=%b want 0 0 1", pushout, doutix, rdyout); end
    reset = 0;
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (pushout !== 1'b0) begin errors++; $display("FAIL midrst_stale%0d got %b want 0", c, pushout); end
      step();
    end
  endtask

  task automatic test_small_wrap();
    logic [15:0] exp_d [4] = '{16'h0307, 16'h1234, 16'h8001, 16'h00FF};
    logic [1:0] exp_p [4] = '{2'b01, 2'b01, 2'b11, 2'b00};
    s_pushin = 1; s_din = 64'h00FF_8001_1234_0307; s_tagin = 8'h3C;
    step();
    s_pushin = 0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (s_pushout !== 1'b1 || s_doutix !== 2'(k) || s_dout !== exp_d[k] || s_tagout !== 8'h3C || s_lastout !== (k == 3)) begin
        errors++; $display("FAIL small_beat%0d got push=%b ix=%0d dout=%h last=%b want 1 %0d %h %b", k, s_pushout,
                           s_doutix, s_dout, s_lastout, k, exp_d[k], k == 3);
      end
`ifdef SHA_OUT_PARITY_EN
      checks++;
      if (s_parout !== exp_p[k]) begin errors++; $display("FAIL small_par%0d got %b want %b", k, s_parout, exp_p[k]); end
`else
      if (exp_p[k] === 2'bxx) $display("unreachable");
`endif
      step();
    end
    checks++; if (s_pushout !== 1'b0 || s_doutix !== 2'd0) begin
      errors++; $display("FAIL small_wrap got push=%b ix=%0d want 0 0", s_pushout, s_doutix); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall();
    test_full_pop_push();
    test_reset_mid();
    test_small_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
